// File: rtl/lab1_imul_mul_arbiter.sv
// rtl/lab1_imul_mul_arbiter.sv - round-robin arbiter sharing one iterative multiplier among NUM_REQ val/rdy clients
// Optional LAB1_IMUL_ARB_STATS_EN adds xact_count/busy_count statistics outputs.
module lab1_imul_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    in_req_val,
  output logic [NUM_REQ-1:0]    in_req_rdy,
  input  logic [NUM_REQ*64-1:0] in_req_msg,
  output logic [NUM_REQ-1:0]    in_resp_val,
  input  logic [NUM_REQ-1:0]    in_resp_rdy,
  output logic [31:0]           in_resp_msg,
  output logic                  mul_req_val,
  input  logic                  mul_req_rdy,
  output logic [63:0]           mul_req_msg,
  input  logic                  mul_resp_val,
  output logic                  mul_resp_rdy,
  input  logic [31:0]           mul_resp_msg,
  output logic [ID_W-1:0]       grant_id
`ifdef LAB1_IMUL_ARB_STATS_EN
  ,
  output logic [31:0]           xact_count,
  output logic [31:0]           busy_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [ID_W:0] LP_N = (ID_W+1)'(NUM_REQ);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_owner;
  logic            r_lock;
  logic [31:0]     r_resp;

  logic [ID_W-1:0] w_winner;
  logic            w_any;
  logic [ID_W:0]   w_idx;
  logic [ID_W-1:0] w_sel;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            w_req_xfer;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= LP_N) w_idx = w_idx - LP_N;
      if (!w_any && in_req_val[w_idx[ID_W-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  // A stalled request keeps its owner so mul_req_msg cannot change under it.
  assign w_sel      = r_lock ? r_owner : w_winner;
  assign w_ptr_nxt  = (w_sel == ID_W'(NUM_REQ-1)) ? '0 : w_sel + ID_W'(1);
  assign w_req_xfer = mul_req_val && mul_req_rdy;
  assign in_resp_msg = r_resp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    in_req_rdy   = '0;
    in_resp_val  = '0;
    mul_req_val  = 1'b0;
    mul_req_msg  = '0;
    mul_resp_rdy = 1'b0;
    grant_id     = '0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          mul_req_val = |in_req_val;
          if (w_any) begin
            mul_req_msg       = in_req_msg[64*w_sel +: 64];
            in_req_rdy[w_sel] = mul_req_rdy;
            grant_id          = w_sel;
          end
          if (mul_req_val && mul_req_rdy) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          mul_resp_rdy = 1'b1;
          grant_id     = r_owner;
          if (mul_resp_val) w_state_nxt = S_RESP;
        end
        S_RESP: begin
          in_resp_val[r_owner] = 1'b1;
          grant_id             = r_owner;
          if (in_resp_rdy[r_owner]) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_lock   <= 1'b0;
      r_resp   <= '0;
    end else begin
      if (w_req_xfer) begin
        r_owner  <= w_sel;
        r_rr_ptr <= w_ptr_nxt;
        r_lock   <= 1'b0;
      end else if (r_state == S_IDLE && mul_req_val && !r_lock) begin
        r_lock  <= 1'b1;
        r_owner <= w_winner;
      end
      if (r_state == S_WAIT && mul_resp_val) r_resp <= mul_resp_msg;
    end
  end

`ifdef LAB1_IMUL_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xact_count <= '0;
      busy_count <= '0;
    end else begin
      if (|(in_resp_val & in_resp_rdy)) xact_count <= xact_count + 32'd1;
      if (r_state != S_IDLE)            busy_count <= busy_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // VC_ASSERT: a multiplier response is only legal while waiting for one.
  vc_assert_resp_in_wait: assert property (
    @(posedge clk) disable iff (!reset) mul_resp_val |-> (r_state == S_WAIT));
`endif

endmodule
